mmio_decoder: RTL and testbench
===============================

MMIO_DECODER -- requirements
Module: mmio_decoder

Interface
REQ-001 Parameter NUM_SLAVES, default 4: number of slave regions, range 1..16.
REQ-002 Parameter REGION_MAP, default mmio_pkg::DEFAULT_MAP: per-slave base/size array, index 0..NUM_SLAVES-1.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum wait for slave read_valid, range 2..255.
REQ-004 clk  input  1  single clock, all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 address  input  32  master byte address, held stable while busy=1.
REQ-007 write_data  input  32  master write data.
REQ-008 write_mask  input  4  byte enables, forwarded unchanged.
REQ-009 write_enable  input  1  master write request, single cycle.
REQ-010 read_enable  input  1  master read request, single cycle.
REQ-011 read_data  output  32  read response data, valid only while read_valid=1.
REQ-012 read_valid  output  1  one-cycle read completion pulse.
REQ-013 bus_error  output  1  one-cycle pulse: unmapped access or read timeout.
REQ-014 busy  output  1  read in flight; master issues no new access while high.
REQ-015 slv_write_enable  output  NUM_SLAVES  per-slave write strobe.
REQ-016 slv_read_enable  output  NUM_SLAVES  per-slave read strobe.
REQ-017 slv_read_data  input  NUM_SLAVES x 32  per-slave read data.
REQ-018 slv_read_valid  input  NUM_SLAVES  per-slave read completion.

Function
REQ-019 Region i SHALL match when base_i <= address < base_i+size_i, computed at 33 bits so regions ending at 2^32 do not wrap; size 0 disables region.
REQ-020 Overlapping matches SHALL resolve to the lowest index.
REQ-021 Writes SHALL be combinational: slv_write_enable[i] = write_enable AND match_i AND state==IDLE, zero latency.
REQ-022 Unmapped write SHALL pulse bus_error in the following cycle; no slave strobe.
REQ-023 FSM states IDLE, WAIT, RESP; reset to IDLE.
REQ-024 IDLE + read_enable + match i: pulse slv_read_enable[i] same cycle, latch index and clear timeout counter, go WAIT.
REQ-025 IDLE + read_enable + no match: go RESP with latched data 32'h0 and error flag set.
REQ-026 WAIT: when slv_read_valid[idx]=1, latch slv_read_data[idx], go RESP; valid on other slaves ignored.
REQ-027 WAIT: counter increments per cycle; reaching TIMEOUT_CYCLES without valid latches 32'hDEAD_BEEF, sets error flag, goes RESP.
REQ-028 Valid arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win (no error).
REQ-029 RESP: read_valid=1, read_data=latched data, bus_error=error flag, for exactly one cycle, then IDLE.
REQ-030 Read latency: minimum 2 cycles from read_enable to read_valid for a slave returning valid the next cycle; unmapped reads exactly 1 cycle.
REQ-031 busy SHALL be 1 in WAIT and RESP, 0 in IDLE.
REQ-032 read_enable and write_enable together in IDLE: write forwarded per REQ-021 and read started per REQ-024/025.
REQ-033 read_enable or write_enable while busy=1 SHALL be ignored without strobes or error.

Reset
REQ-034 On rst=1 at a clock edge: state IDLE, counter 0, latched data 0, read_valid 0, bus_error 0, busy 0.
REQ-035 Reset mid-read SHALL abandon the transaction; a late slv_read_valid afterwards SHALL be ignored.
REQ-036 slv_* strobes SHALL be 0 during reset regardless of inputs.

Structure
REQ-037 mmio_pkg SHALL hold region_t {base, size}, MAX_SLAVES=16, DEFAULT_MAP (imem 0x8000_0000/0x800, dmem 0x9000_0000/0x800, uart 0x1001_0000/0x200, gpio 0xA000_0000/0x200), TIMEOUT_RDATA=32'hDEAD_BEEF.
REQ-038 One sub-module mmio_addr_match SHALL produce match vector and winning index from address and REGION_MAP.
REQ-039 Target size 120-400 lines RTL total.

Verification
REQ-040 Read 0x9000_0010, dmem valid 1 cycle later with 0x1234_5678 -> read_valid at cycle+2, data 0x1234_5678, bus_error 0.
REQ-041 Write 0x1001_0000 data 0x41 mask 0x1 -> slv_write_enable=4'b0100 same cycle, no bus_error.
REQ-042 Read 0x5000_0000 -> next cycle read_valid=1, read_data 0, bus_error 1.
REQ-043 Read 0xA000_0000, gpio never valid, TIMEOUT_CYCLES=16 -> RESP after 16 WAIT cycles, data 0xDEAD_BEEF, bus_error 1; valid on cycle 16 -> normal data, no error.
REQ-044 rst asserted in WAIT, slave valid 2 cycles later -> no read_valid, busy 0, state IDLE.
REQ-045 Overlap map region0 0x0/0x100, region1 0x80/0x100, read 0x90 -> slv_read_enable=4'b0001.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO address decoder: region map layout,
// FSM state encoding and the default four-slave memory map.
package mmio_pkg;

    localparam int MAX_SLAVES = 16;
    localparam int IDX_W      = 4;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] size;
    } region_t;

    typedef region_t [MAX_SLAVES-1:0] region_map_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Unused entries keep size 0, which disables them.
    function automatic region_map_t build_default_map();
        region_map_t m;
        m    = '0;
        m[0] = '{base: 32'h8000_0000, size: 32'h0000_0800};
        m[1] = '{base: 32'h9000_0000, size: 32'h0000_0800};
        m[2] = '{base: 32'h1001_0000, size: 32'h0000_0200};
        m[3] = '{base: 32'hA000_0000, size: 32'h0000_0200};
        return m;
    endfunction

    localparam region_map_t DEFAULT_MAP = build_default_map();

endpackage

// File: rtl/mmio_decoder_if.sv
// Master-side MMIO bus: one request channel plus the read response and status
// lines returned by the decoder.
interface mmio_decoder_if;

    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] read_data;
    logic        read_valid;
    logic        bus_error;
    logic        busy;

    modport master (
        output address, write_data, write_mask, write_enable, read_enable,
        input  read_data, read_valid, bus_error, busy
    );

    modport slave (
        input  address, write_data, write_mask, write_enable, read_enable,
        output read_data, read_valid, bus_error, busy
    );

endinterface

// File: rtl/mmio_addr_match.sv
// Region comparator: raw per-region hit vector plus the lowest-index winner.
// Bounds are evaluated at 33 bits so a region ending exactly at 2^32 works.
module mmio_addr_match
    import mmio_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter region_map_t REGION_MAP = DEFAULT_MAP
) (
    input  logic [31:0]           address,
    output logic [NUM_SLAVES-1:0] match,
    output logic [IDX_W-1:0]      win_idx
);

    // Per-region range check; a zero-size region never matches.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            match[i] = (REGION_MAP[i].size != 32'h0000_0000) &&
                       ({1'b0, address} >= {1'b0, REGION_MAP[i].base}) &&
                       ({1'b0, address} <  ({1'b0, REGION_MAP[i].base} +
                                            {1'b0, REGION_MAP[i].size}));
        end
    end

    // Scan downward so the lowest matching index is written last and wins.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            win_idx = match[i] ? IDX_W'(i) : win_idx;
        end
    end

endmodule

// File: rtl/mmio_decoder.sv
// MMIO decoder: forwards writes combinationally to the matching slave and
// runs a single outstanding read with timeout through an IDLE/WAIT/RESP FSM.
module mmio_decoder
    import mmio_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter region_map_t REGION_MAP     = DEFAULT_MAP,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    mmio_decoder_if.slave              bus,
    output logic [NUM_SLAVES-1:0]      slv_write_enable,
    output logic [NUM_SLAVES-1:0]      slv_read_enable,
    input  logic [NUM_SLAVES-1:0][31:0] slv_read_data,
    input  logic [NUM_SLAVES-1:0]      slv_read_valid
);

    localparam logic [7:0] TMO_LAST_C = 8'(TIMEOUT_CYCLES - 1);

    logic [NUM_SLAVES-1:0] match_s;
    logic [IDX_W-1:0]      win_idx_s;
    logic                  hit_s;
    logic [NUM_SLAVES-1:0] sel_onehot_s;
    logic                  sel_valid_s;
    logic [31:0]           sel_data_s;
    logic                  idle_s;

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [31:0] rdata_r, rdata_s;
    logic        err_r, err_s;
    logic        wr_err_r;

    mmio_addr_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .REGION_MAP (REGION_MAP)
    ) u_match (
        .address (bus.address),
        .match   (match_s),
        .win_idx (win_idx_s)
    );

    assign hit_s  = |match_s;
    assign idle_s = (state_r == IDLE) && !rst;

    // Winner one-hot for strobes, and response mux driven by the latched index.
    always_comb begin
        sel_onehot_s = '0;
        sel_valid_s  = 1'b0;
        sel_data_s   = 32'h0000_0000;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_onehot_s[i] = hit_s && (win_idx_s == IDX_W'(i));
            sel_valid_s     = sel_valid_s | (slv_read_valid[i] && (idx_r == IDX_W'(i)));
            sel_data_s      = (idx_r == IDX_W'(i)) ? slv_read_data[i] : sel_data_s;
        end
    end

    assign slv_write_enable = (idle_s && bus.write_enable) ? sel_onehot_s : '0;
    assign slv_read_enable  = (idle_s && bus.read_enable)  ? sel_onehot_s : '0;

    // Next-state logic; a valid in the final WAIT cycle takes priority over timeout.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        rdata_s = rdata_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (bus.read_enable) begin
                    if (hit_s) begin
                        idx_s   = win_idx_s;
                        cnt_s   = 8'd0;
                        err_s   = 1'b0;
                        state_s = WAIT;
                    end else begin
                        rdata_s = 32'h0000_0000;
                        err_s   = 1'b1;
                        state_s = RESP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (sel_valid_s) begin
                    rdata_s = sel_data_s;
                    err_s   = 1'b0;
                    state_s = RESP;
                end else if (cnt_r == TMO_LAST_C) begin
                    rdata_s = TIMEOUT_RDATA;
                    err_s   = 1'b1;
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and response registers; unmapped writes flag an error one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= 8'd0;
            idx_r    <= '0;
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
            wr_err_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            rdata_r  <= rdata_s;
            err_r    <= err_s;
            wr_err_r <= (state_r == IDLE) && bus.write_enable && !hit_s;
        end
    end

    assign bus.read_valid = (state_r == RESP);
    assign bus.read_data  = (state_r == RESP) ? rdata_r : 32'h0000_0000;
    assign bus.bus_error  = ((state_r == RESP) && err_r) || wr_err_r;
    assign bus.busy       = (state_r != IDLE);

endmodule

// File: tb/tb_mmio_decoder.sv
// Directed bench for mmio_decoder: read responses are checked against a
// scoreboard queue, strobes and status against fixed expectations.
module tb_mmio_decoder;
    import mmio_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmio_decoder_if bus ();
    mmio_decoder_if bus_ov ();

    logic [3:0]       swe, sre, sv;
    logic [3:0][31:0] sd;
    logic [3:0]       swe_ov, sre_ov, sv_ov;
    logic [3:0][31:0] sd_ov;

    function automatic region_map_t mk_ov_map();
        region_map_t m;
        m    = '0;
        m[0] = '{base: 32'h0000_0000, size: 32'h0000_0100};
        m[1] = '{base: 32'h0000_0080, size: 32'h0000_0100};
        m[2] = '{base: 32'hFFFF_FF00, size: 32'h0000_0100};
        return m;
    endfunction

    localparam region_map_t OV_MAP = mk_ov_map();

    mmio_decoder #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .slv_write_enable(swe), .slv_read_enable(sre),
        .slv_read_data(sd), .slv_read_valid(sv)
    );

    mmio_decoder #(.NUM_SLAVES(4), .REGION_MAP(OV_MAP), .TIMEOUT_CYCLES(16)) dut_ov (
        .clk(clk), .rst(rst), .bus(bus_ov),
        .slv_write_enable(swe_ov), .slv_read_enable(sre_ov),
        .slv_read_data(sd_ov), .slv_read_valid(sv_ov)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        resp_t e;
        @(posedge clk);
        #1;
        if (bus.read_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_read_valid observed=1 expected=0");
            end else begin
                e = exp_q.pop_front();
                chk("resp_data", bus.read_data, e.data);
                chk("resp_err", 32'(bus.bus_error), 32'(e.err));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.address = 32'h0; bus.write_data = 32'h0; bus.write_mask = 4'h0;
        bus.write_enable = 1'b0; bus.read_enable = 1'b0;
        bus_ov.address = 32'h0; bus_ov.write_data = 32'h0; bus_ov.write_mask = 4'h0;
        bus_ov.write_enable = 1'b0; bus_ov.read_enable = 1'b0;
        sv = 4'h0; sd = '0; sv_ov = 4'h0; sd_ov = '0;

        // Reset: strobes held low, status cleared
        step();
        bus.address = 32'h9000_0000; bus.write_enable = 1'b1; bus.read_enable = 1'b1;
        #1;
        chk("rst_swe", 32'(swe), 32'h0);
        chk("rst_sre", 32'(sre), 32'h0);
        step();
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_rvalid", 32'(bus.read_valid), 32'h0);
        chk("rst_berr", 32'(bus.bus_error), 32'h0);
        bus.write_enable = 1'b0; bus.read_enable = 1'b0;
        rst = 1'b0;
        step();

        // Overlap priority and 2^32 end boundary (combinational only)
        bus_ov.read_enable = 1'b1;
        bus_ov.address = 32'h0000_0090; #1; chk("ov_overlap", 32'(sre_ov), 32'h1);
        bus_ov.address = 32'h0000_0100; #1; chk("ov_r1_only", 32'(sre_ov), 32'h2);
        bus_ov.address = 32'h0000_0180; #1; chk("ov_r1_end", 32'(sre_ov), 32'h0);
        bus_ov.address = 32'hFFFF_FFFC; #1; chk("ov_top", 32'(sre_ov), 32'h4);
        bus_ov.read_enable = 1'b0;

        // Mapped write to uart
        bus.address = 32'h1001_0000; bus.write_data = 32'h41; bus.write_mask = 4'h1;
        bus.write_enable = 1'b1;
        #1; chk("wr_swe", 32'(swe), 32'h4);
        step();
        bus.write_enable = 1'b0;
        chk("wr_berr", 32'(bus.bus_error), 32'h0);

        // Unmapped write: error pulse next cycle only
        bus.address = 32'h5000_0000; bus.write_enable = 1'b1;
        #1; chk("uwr_swe", 32'(swe), 32'h0);
        step();
        bus.write_enable = 1'b0;
        chk("uwr_berr", 32'(bus.bus_error), 32'h1);
        step();
        chk("uwr_berr_clr", 32'(bus.bus_error), 32'h0);

        // dmem read with valid one cycle later
        bus.address = 32'h9000_0010; bus.read_enable = 1'b1;
        #1; chk("rd_sre", 32'(sre), 32'h2);
        exp_q.push_back('{data: 32'h1234_5678, err: 1'b0});
        step();
        bus.read_enable = 1'b0;
        chk("rd_busy", 32'(bus.busy), 32'h1);
        chk("rd_wait_rv", 32'(bus.read_valid), 32'h0);
        sv = 4'h2; sd[1] = 32'h1234_5678;
        step();
        chk("rd_rv", 32'(bus.read_valid), 32'h1);
        sv = 4'h0;
        step();
        chk("rd_idle_busy", 32'(bus.busy), 32'h0);

        // Unmapped read, including the exclusive end of dmem
        bus.address = 32'h9000_0800; bus.read_enable = 1'b1;
        #1; chk("end_sre", 32'(sre), 32'h0);
        bus.address = 32'h5000_0000;
        #1; chk("urd_sre", 32'(sre), 32'h0);
        exp_q.push_back('{data: 32'h0, err: 1'b1});
        step();
        bus.read_enable = 1'b0;
        chk("urd_rv", 32'(bus.read_valid), 32'h1);
        chk("urd_busy", 32'(bus.busy), 32'h1);
        step();
        chk("urd_berr_clr", 32'(bus.bus_error), 32'h0);

        // gpio read never answered: timeout after 16 WAIT cycles
        bus.address = 32'hA000_0000; bus.read_enable = 1'b1;
        #1; chk("tmo_sre", 32'(sre), 32'h8);
        exp_q.push_back('{data: 32'hDEAD_BEEF, err: 1'b1});
        step();
        bus.read_enable = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            chk("tmo_wait_rv", 32'(bus.read_valid), 32'h0);
        end
        step();
        chk("tmo_rv", 32'(bus.read_valid), 32'h1);
        step();

        // Valid in the final WAIT cycle wins over timeout
        bus.read_enable = 1'b1;
        exp_q.push_back('{data: 32'hCAFE_0003, err: 1'b0});
        step();
        bus.read_enable = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
        end
        sv = 4'h8; sd[3] = 32'hCAFE_0003;
        step();
        chk("late_rv", 32'(bus.read_valid), 32'h1);
        sv = 4'h0;
        step();

        // Requests while busy ignored; valid from another slave ignored
        bus.address = 32'h9000_0020; bus.read_enable = 1'b1;
        exp_q.push_back('{data: 32'h0BAD_F00D, err: 1'b0});
        step();
        bus.write_enable = 1'b1;
        sv = 4'h1; sd[0] = 32'h1111_1111;
        #1;
        chk("busy_swe", 32'(swe), 32'h0);
        chk("busy_sre", 32'(sre), 32'h0);
        step();
        chk("busy_other_rv", 32'(bus.read_valid), 32'h0);
        chk("busy_berr", 32'(bus.bus_error), 32'h0);
        bus.write_enable = 1'b0; bus.read_enable = 1'b0;
        sv = 4'h2; sd[1] = 32'h0BAD_F00D;
        step();
        chk("busy_rv", 32'(bus.read_valid), 32'h1);
        sv = 4'h0;
        step();

        // Simultaneous read and write in IDLE
        bus.address = 32'h9000_0000; bus.write_enable = 1'b1; bus.read_enable = 1'b1;
        #1;
        chk("rw_swe", 32'(swe), 32'h2);
        chk("rw_sre", 32'(sre), 32'h2);
        exp_q.push_back('{data: 32'hABCD_0001, err: 1'b0});
        step();
        bus.write_enable = 1'b0; bus.read_enable = 1'b0;
        sv = 4'h2; sd[1] = 32'hABCD_0001;
        step();
        sv = 4'h0;
        step();

        // Reset during WAIT abandons the read; late valid ignored
        bus.address = 32'h8000_0000; bus.read_enable = 1'b1;
        #1; chk("rr_sre", 32'(sre), 32'h1);
        step();
        bus.read_enable = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_busy", 32'(bus.busy), 32'h0);
        step();
        sv = 4'h1; sd[0] = 32'h7777_7777;
        step();
        chk("rr_rv", 32'(bus.read_valid), 32'h0);
        chk("rr_busy2", 32'(bus.busy), 32'h0);
        sv = 4'h0;
        step();

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
